// File: rtl/checksum_verify_scheduler.sv
// Streams the (N+1)x(N+1) full-checksum matrix Cf row by row into the checksum verifier
// and records the first faulty row/column. Optional per-row handshake timeout: CKV_TIMEOUT_EN.
module checksum_verify_scheduler #(
  parameter int N       = 32,
  parameter int DW      = 32,
  parameter int RW      = 6,
  parameter int DRAIN   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic                multi_err,
  output logic                timeout,
  output logic [RW-1:0]       err_row,
  output logic [N:0]          err_col,
  output logic                row_rd_en,
  output logic [RW-1:0]       row_rd_addr,
  input  logic [(N+1)*DW-1:0] row_rd_data,
  output logic                verify_enable,
  output logic [1:0]          detect_correct,
  output logic                fetch_Cf_row,
  output logic [(N+1)*DW-1:0] dataCf_in,
  input  logic [N:0]          column_indicator,
  input  logic                error,
  input  logic                column_verify_ready
);

  localparam int CMAX = (TIMEOUT > DRAIN) ? TIMEOUT : DRAIN;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RD, S_LD, S_FETCH, S_GAP, S_DRAIN, S_FIN
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [RW-1:0] row;
  logic          start_ok, row_done, last_row, tmo;

  assign start_ok = start && (mode == 2'd1 || mode == 2'd2);
  assign row_done = column_verify_ready || error;
  assign last_row = (row == RW'(N));

`ifdef CKV_TIMEOUT_EN
  assign tmo = (state == S_FETCH) && !row_done && (cnt == CW'(TIMEOUT - 1));
`else
  assign tmo     = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = S_ARM;
      S_ARM:   if (cnt == CW'(1)) state_nx = S_RD;
      S_RD:    state_nx = S_LD;
      S_LD:    state_nx = S_FETCH;
      S_FETCH: begin
        // In detect mode one faulty row is enough; correct mode scans every row.
        if (row_done) begin
          if ((error && detect_correct == 2'd1) || last_row) state_nx = S_DRAIN;
          else                                               state_nx = S_GAP;
        end else if (tmo) begin
          state_nx = S_DRAIN;
        end
      end
      S_GAP:   state_nx = S_RD;
      S_DRAIN: if (cnt == CW'(DRAIN - 1)) state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Shared cycle counter: ARM setup, FETCH timeout and DRAIN hold all restart on state entry.
  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (state_nx != state) cnt <= '0;
    else                        cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                                row <= '0;
    else if (state == S_IDLE && start_ok)   row <= '0;
    else if (state == S_GAP && !last_row)   row <= row + RW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      detect_correct <= '0;
      fault          <= 1'b0;
      multi_err      <= 1'b0;
      err_row        <= '0;
      err_col        <= '0;
      dataCf_in      <= '0;
    end else begin
      if (state == S_IDLE && start_ok) begin
        detect_correct <= mode;
        fault          <= 1'b0;
        multi_err      <= 1'b0;
        err_row        <= '0;
        err_col        <= '0;
      end
      if (state == S_LD) dataCf_in <= row_rd_data;
      if (state == S_FETCH) begin
        if (error) begin
          if (!fault) begin
            fault   <= 1'b1;
            err_row <= row;
            err_col <= column_indicator;
          end else begin
            multi_err <= 1'b1;
          end
        end else if (tmo) begin
          fault   <= 1'b1;
          err_row <= row;
          err_col <= '0;
        end
      end
    end
  end

`ifdef CKV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)                              timeout <= 1'b0;
    else if (state == S_IDLE && start_ok) timeout <= 1'b0;
    else if (tmo)                         timeout <= 1'b1;
  end
`endif

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_FIN);
  assign row_rd_en     = (state == S_RD);
  assign row_rd_addr   = row;
  assign fetch_Cf_row  = (state == S_FETCH);
  assign verify_enable = (state != S_IDLE) && (state != S_FIN);

endmodule

// File: tb/tb_checksum_verify_scheduler.sv
// Self-checking bench for checksum_verify_scheduler: row-buffer and verifier models plus a
// pass-level expectation model. Timeout case is exercised when CKV_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_checksum_verify_scheduler;
  localparam int N = 32, DW = 32, RW = 6, DRAIN = 3, TIMEOUT = 64;
  localparam int RB = (N + 1) * DW;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [1:0]    mode;
  logic          busy, done, fault, multi_err, timeout;
  logic [RW-1:0] err_row, row_rd_addr;
  logic [N:0]    err_col, column_indicator;
  logic          row_rd_en, verify_enable, fetch_Cf_row, error, column_verify_ready;
  logic [RB-1:0] row_rd_data, dataCf_in;
  logic [1:0]    detect_correct;

  checksum_verify_scheduler #(.N(N), .DW(DW), .RW(RW), .DRAIN(DRAIN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
    .fault(fault), .multi_err(multi_err), .timeout(timeout), .err_row(err_row),
    .err_col(err_col), .row_rd_en(row_rd_en), .row_rd_addr(row_rd_addr),
    .row_rd_data(row_rd_data), .verify_enable(verify_enable),
    .detect_correct(detect_correct), .fetch_Cf_row(fetch_Cf_row), .dataCf_in(dataCf_in),
    .column_indicator(column_indicator), .error(error),
    .column_verify_ready(column_verify_ready));

  always #5 clk = ~clk;

  logic [RB-1:0] golden [0:N];
  logic [RB-1:0] mem    [0:N];

  int checks = 0, errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Row buffer: data valid one cycle after the read strobe.
  always @(posedge clk) if (row_rd_en) row_rd_data <= mem[row_rd_addr];

  // Verifier model: answers after a random latency; a row is faulty where the presented
  // data differs from the golden matrix.
  int            vcnt, vlat, withhold_row = -1;
  longint        vtime_total = 0;
  bit            vresp;
  logic [RW-1:0] vrow;
  logic [N:0]    vmask;
  initial begin : verifier
    column_verify_ready = 1'b0; error = 1'b0; column_indicator = '0;
    vcnt = 0; vresp = 1'b0; vlat = 1; vrow = '0;
    forever begin
      @(negedge clk);
      column_verify_ready = 1'b0; error = 1'b0; column_indicator = '0;
      if (row_rd_en) vrow = row_rd_addr;
      if (fetch_Cf_row && !rst) begin
        vcnt++;
        if (!vresp && vcnt >= vlat && int'(vrow) != withhold_row) begin
          vmask = '0;
          for (int c = 0; c <= N; c++)
            if (dataCf_in[c*DW +: DW] != golden[vrow][c*DW +: DW]) vmask[c] = 1'b1;
          vresp = 1'b1;
          vtime_total += vcnt;
          if (vmask != '0) begin
            error = 1'b1;
            column_indicator = vmask;
            column_verify_ready = 1'($urandom_range(0, 1));
          end else begin
            column_verify_ready = 1'b1;
          end
        end
      end else begin
        vcnt = 0; vresp = 1'b0; vlat = $urandom_range(1, 3);
      end
    end
  end

  // Pass-level expectations, filled in before each start.
  logic [1:0]    exp_mode = 2'd0;
  int            exp_reads;
  logic          exp_fault, exp_multi, exp_tmo;
  logic [RW-1:0] exp_err_row;
  logic [N:0]    exp_err_col;
  longint        vtime_base;

  function automatic logic [N:0] colMask(input int r);
    logic [N:0] m = '0;
    for (int c = 0; c <= N; c++)
      if (mem[r][c*DW +: DW] != golden[r][c*DW +: DW]) m[c] = 1'b1;
    return m;
  endfunction

  task automatic setExpect(input logic [1:0] m, input int wh);
    int f = -1, cnt = 0;
    exp_mode = m; withhold_row = wh; vtime_base = vtime_total;
    exp_fault = 1'b0; exp_multi = 1'b0; exp_tmo = 1'b0;
    exp_err_row = '0; exp_err_col = '0; exp_reads = N + 1;
    for (int r = 0; r <= N; r++)
      if (mem[r] != golden[r]) begin
        if (f < 0) f = r;
        cnt++;
      end
    if (wh >= 0) begin
      exp_reads = wh + 1; exp_tmo = 1'b1; exp_fault = 1'b1; exp_err_row = RW'(wh);
    end else if (f >= 0) begin
      exp_fault = 1'b1; exp_err_row = RW'(f); exp_err_col = colMask(f);
      if (m == 2'd1) exp_reads = f + 1;
      else           exp_multi = (cnt >= 2);
    end
  endtask

  // Per-cycle monitor: read order, presented data, mode, drain length and pass latency.
  int            pass_cyc, reads, tail, next_addr, max_addr, done_total = 0;
  bit            prev_busy = 1'b0;
  logic [RB-1:0] mon_row;
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        pass_cyc = 0; reads = 0; tail = 0; next_addr = 0; max_addr = 0;
      end
      if (busy) begin
        pass_cyc++;
        checkOutput("detect_correct", 64'(detect_correct), 64'(exp_mode));
      end else begin
        checkOutput("rd_en_idle", 64'(row_rd_en), 64'(0));
      end
`ifndef CKV_TIMEOUT_EN
      checkOutput("timeout_tied", 64'(timeout), 64'(0));
`endif
      if (row_rd_en) begin
        checkOutput("row_rd_addr", 64'(row_rd_addr), 64'(next_addr));
        next_addr++; reads++;
        if (int'(row_rd_addr) > max_addr) max_addr = int'(row_rd_addr);
        mon_row = mem[row_rd_addr];
      end
      if (fetch_Cf_row) begin
        tail = 0;
        checks++;
        if (dataCf_in !== mon_row) begin
          errors++;
          $display("[TB] FAIL dataCf_in actual_lo=%0h required_lo=%0h", dataCf_in[63:0], mon_row[63:0]);
        end
        checkOutput("ve_in_fetch", 64'(verify_enable), 64'(1));
      end else if (row_rd_en) begin
        tail = 0;
      end else if (verify_enable) begin
        tail++;
      end
      if (done) begin
        done_total++;
        checkOutput("ve_at_done", 64'(verify_enable), 64'(0));
        checkOutput("drain_len", 64'(tail), 64'(DRAIN));
        checkOutput("pass_latency", 64'(pass_cyc),
                    64'(2 + exp_reads * 3 + (vtime_total - vtime_base) +
                        (exp_tmo ? TIMEOUT : 0) - 1 + DRAIN + 1));
        checkOutput("reads", 64'(reads), 64'(exp_reads));
        checkOutput("fault", 64'(fault), 64'(exp_fault));
        checkOutput("multi_err", 64'(multi_err), 64'(exp_multi));
        checkOutput("err_row", 64'(err_row), 64'(exp_err_row));
        checkOutput("err_col", 64'(err_col), 64'(exp_err_col));
        checkOutput("timeout", 64'(timeout), 64'(exp_tmo));
      end
      prev_busy = busy;
    end
  end

  task automatic buildGolden(input bit rnd);
    logic [DW-1:0] e [0:N][0:N];
    for (int r = 0; r <= N; r++)
      for (int c = 0; c <= N; c++) e[r][c] = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        e[r][c] = rnd ? DW'($urandom_range(0, 1000)) : DW'(2);
        e[r][N] = e[r][N] + e[r][c];
      end
    for (int c = 0; c <= N; c++)
      for (int r = 0; r < N; r++) e[N][c] = e[N][c] + e[r][c];
    for (int r = 0; r <= N; r++) begin
      for (int c = 0; c <= N; c++) golden[r][c*DW +: DW] = e[r][c];
      mem[r] = golden[r];
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m);
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0; mode = 2'd0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    checkOutput({name, "_done_seen"}, 64'(done), 64'(1));
    @(negedge clk);
    checkOutput({name, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    int d0, n;
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    buildGolden(1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_fault", 64'(fault), 64'(0));
    checkOutput("rst_ve", 64'(verify_enable), 64'(0));
    checkOutput("rst_fetch", 64'(fetch_Cf_row), 64'(0));
    checkOutput("rst_rd_en", 64'(row_rd_en), 64'(0));
    checkOutput("rst_err_row", 64'(err_row), 64'(0));
    checkOutput("rst_err_col", 64'(err_col), 64'(0));
    checkOutput("rst_mode", 64'(detect_correct), 64'(0));
    checkOutput("rst_data", 64'(|dataCf_in), 64'(0));
    rst = 1'b0;

    // Case 1: clean detect pass over the all-2 matrix.
    checkOutput("t1_rowsum", 64'(golden[0][N*DW +: DW]), 64'(64));
    checkOutput("t1_corner", 64'(golden[N][N*DW +: DW]), 64'(2048));
    setExpect(2'd1, -1); applyStimulus(2'd1); waitDone("t1");
    checkOutput("t1_reads", 64'(reads), 64'(33));
    checkOutput("t1_fault", 64'(fault), 64'(0));

    // Case 2: detect mode stops at the first faulty row.
    mem[0][16*DW +: DW] = DW'(1);
    setExpect(2'd1, -1); applyStimulus(2'd1); waitDone("t2");
    checkOutput("t2_err_row", 64'(err_row), 64'(0));
    checkOutput("t2_err_col", 64'(err_col), 64'h1_0000);
    checkOutput("t2_fault", 64'(fault), 64'(1));
    checkOutput("t2_max_addr", 64'(max_addr), 64'(0));

    // Case 3: correct mode scans all rows and flags a second faulty row.
    buildGolden(1'b0);
    mem[5][7*DW +: DW] = DW'(9);
    mem[9][3*DW +: DW] = DW'(0);
    setExpect(2'd2, -1); applyStimulus(2'd2); waitDone("t3");
    checkOutput("t3_err_row", 64'(err_row), 64'(5));
    checkOutput("t3_err_col", 64'(err_col), 64'h80);
    checkOutput("t3_multi", 64'(multi_err), 64'(1));
    checkOutput("t3_reads", 64'(reads), 64'(33));

    // Case 4: reset while row 10 is being fetched, then a clean pass.
    buildGolden(1'b0);
    setExpect(2'd1, -1); applyStimulus(2'd1);
    d0 = done_total; n = 0;
    while (!(fetch_Cf_row && vrow == RW'(10)) && n < 1000) begin @(negedge clk); n++; end
    checkOutput("t4_reached_row10", 64'(fetch_Cf_row), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t4_busy", 64'(busy), 64'(0));
    checkOutput("t4_fetch", 64'(fetch_Cf_row), 64'(0));
    checkOutput("t4_ve", 64'(verify_enable), 64'(0));
    checkOutput("t4_data", 64'(|dataCf_in), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t4_no_done", 64'(done_total), 64'(d0));
    setExpect(2'd1, -1); applyStimulus(2'd1); waitDone("t4b");

    // Case 5: invalid modes are ignored; a start during a pass does not restart it.
    d0 = done_total;
    applyStimulus(2'd0);
    checkOutput("t5_busy_m0", 64'(busy), 64'(0));
    applyStimulus(2'd3);
    repeat (4) @(negedge clk);
    checkOutput("t5_busy_m3", 64'(busy), 64'(0));
    checkOutput("t5_mode_kept", 64'(detect_correct), 64'(1));
    checkOutput("t5_no_done", 64'(done_total), 64'(d0));
    setExpect(2'd1, -1); applyStimulus(2'd1);
    repeat (20) @(negedge clk);
    applyStimulus(2'd2);
    waitDone("t5b");
    checkOutput("t5_one_done", 64'(done_total), 64'(d0 + 1));

`ifdef CKV_TIMEOUT_EN
    // Case 6: verifier never answers row 4.
    buildGolden(1'b0);
    setExpect(2'd1, 4); applyStimulus(2'd1); waitDone("t6");
    checkOutput("t6_timeout", 64'(timeout), 64'(1));
    checkOutput("t6_err_row", 64'(err_row), 64'(4));
    checkOutput("t6_err_col", 64'(err_col), 64'(0));
    withhold_row = -1;
`endif

    // Randomized passes: random matrices, fault sites, modes and verifier latency.
    for (int p = 0; p < 12; p++) begin
      int nf;
      if (p % 4 == 0) buildGolden(1'b1);
      for (int r = 0; r <= N; r++) mem[r] = golden[r];
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        int r, c;
        r = $urandom_range(0, N); c = $urandom_range(0, N);
        mem[r][c*DW +: DW] = mem[r][c*DW +: DW] ^ DW'($urandom_range(1, 255));
      end
      begin
        logic [1:0] m;
        m = 2'($urandom_range(1, 2));
        setExpect(m, -1); applyStimulus(m); waitDone("rand");
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
